counter_24: RTL and testbench



---
 rtl/counter_24.sv | 57 +++++
 tb/tb_counter_24.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/counter_24.sv
// Two-digit BCD hours counter (00..23) with synchronous preset and rollover flag.
// Define COUNTER24_LOAD_CHECK_EN to reject preset values that are not a legal hour.
module counter_24 (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       co
);

  logic [3:0] tens;
  logic [3:0] units;
  logic       cur_valid;
  logic       load_ok;
  logic [7:0] inc_value;

  assign tens  = data_out[7:4];
  assign units = data_out[3:0];

  // Any corrupt value (bad units digit or past 23) recovers to midnight on increment.
  assign cur_valid = (units <= 4'd9) && (data_out <= 8'h23);

  always_comb begin
    inc_value = 8'h00;
    if (!cur_valid || data_out == 8'h23) begin
      inc_value = 8'h00;
    end else if (units == 4'd9) begin
      inc_value = {tens + 4'd1, 4'd0};
    end else begin
      inc_value = {tens, units + 4'd1};
    end
  end

`ifdef COUNTER24_LOAD_CHECK_EN
  assign load_ok = (data_in[3:0] <= 4'd9) && (data_in[7:4] <= 4'd2) && (data_in <= 8'h23);
`else
  assign load_ok = 1'b1;
`endif

  // A rejected load still owns the cycle, so the enable is ignored as well.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= 8'h00;
    end else if (load) begin
      if (load_ok) begin
        data_out <= data_in;
      end
    end else if (en) begin
      data_out <= inc_value;
    end
  end

  assign co = en && !rst && (data_out == 8'h23);

endmodule

// File: tb/tb_counter_24.sv
// Self-checking bench for counter_24: directed hour-counter scenarios plus random
// stimulus compared against an arithmetic (hours-as-integer) reference model.
module tb_counter_24;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic       en;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       co;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] model_q = 8'h00;

  always #5 clk = ~clk;

  counter_24 dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .en      (en),
    .data_in (data_in),
    .data_out(data_out),
    .co      (co)
  );

  function automatic bit is_valid(input logic [7:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) &&
           ((int'(v[7:4]) * 10 + int'(v[3:0])) <= 23);
  endfunction

  // Next hour computed as plain integer arithmetic modulo 24.
  function automatic logic [7:0] next_hour(input logic [7:0] v);
    int h;
    if (!is_valid(v)) return 8'h00;
    h = (int'(v[7:4]) * 10 + int'(v[3:0]) + 1) % 24;
    return {4'(h / 10), 4'(h % 10)};
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic l, input logic e, input logic [7:0] d);
    logic [7:0] nxt;
    @(negedge clk);
    rst = r; load = l; en = e; data_in = d;
    #1;
    checkOutput("co", {7'b0, co}, {7'b0, (!r && e && model_q == 8'h23)});
    if (r) nxt = 8'h00;
    else if (l) begin
`ifdef COUNTER24_LOAD_CHECK_EN
      nxt = is_valid(d) ? d : model_q;
`else
      nxt = d;
`endif
    end
    else if (e) nxt = next_hour(model_q);
    else nxt = model_q;
    @(posedge clk);
    model_q = nxt;
    #1;
    checkOutput("data_out", data_out, model_q);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic r, l, e;
    logic [7:0] d;
    rst = 1'b1; load = 1'b0; en = 1'b0; data_in = 8'h00;

    // Reset dominates load and enable
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 8'h12);
      checkOutput("reset_val", data_out, 8'h00);
    end

    // Count 00 -> 10 -> 20
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("count10", data_out, 8'h10);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("count20", data_out, 8'h20);

    // Wrap through 23
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h22);
    checkOutput("load22", data_out, 8'h22);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("step23", data_out, 8'h23);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("wrap00", data_out, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("wrap01", data_out, 8'h01);

    // Load held while counting
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h05);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1, 8'h12);
    checkOutput("load_hold", data_out, 8'h12);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h12);
    checkOutput("resume13", data_out, 8'h13);

    // Enable low holds; co stays low at 23 without enable
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h17);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("hold17", data_out, 8'h17);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h23);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("hold23_co", {7'b0, co}, 8'h00);

    // Invalid preset
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h3A);
`ifdef COUNTER24_LOAD_CHECK_EN
    checkOutput("bad_load", data_out, 8'h23);
`else
    checkOutput("bad_load", data_out, 8'h3A);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("bad_recover", data_out, 8'h00);
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 49) == 0);
      l = ($urandom_range(0, 7) == 0);
      e = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: d = 8'($urandom);
        1: d = 8'h23;
        2: d = 8'h19;
        default: begin
          int h;
          h = $urandom_range(0, 23);
          d = {4'(h / 10), 4'(h % 10)};
        end
      endcase
      applyStimulus(r, l, e, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
